// File: rtl/cc_muxtransi_seq.sv
// N-channel registered source mux with blanked, handshaked channel transitions.
// Optional feature macro: CC_MUXT_PENDING_EN (one-deep pending request while busy).
module cc_muxtransi_seq #(
  parameter int MUXT_WIDTH      = 8,
  parameter int MUXT_CHANNELS   = 4,
  parameter int MUXT_SELWIDTH   = 2,
  parameter int MUXT_HOLDCYCLES = 3,
  parameter logic [MUXT_WIDTH-1:0] MUXT_BLANK = '0
) (
  input  logic                                CC_MUXT_CLOCK_50,
  input  logic                                CC_MUXT_RESET_InHigh,
  input  logic [MUXT_CHANNELS*MUXT_WIDTH-1:0] CC_MUXT_data_InBUS,
  input  logic [MUXT_SELWIDTH-1:0]            CC_MUXT_select_InBUS,
  input  logic                                CC_MUXT_req_In,
  output logic [MUXT_WIDTH-1:0]               CC_MUXT_data_OutBUS,
  output logic [MUXT_SELWIDTH-1:0]            CC_MUXT_active_OutBUS,
  output logic                                CC_MUXT_busy_Out,
  output logic                                CC_MUXT_done_Out
);

  localparam int  NSEL     = 2**MUXT_SELWIDTH;
  localparam bit  HAS_HOLD = (MUXT_HOLDCYCLES > 0);
  localparam int  CW       = HAS_HOLD ? $clog2(MUXT_HOLDCYCLES+1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = HAS_HOLD ? CW'(MUXT_HOLDCYCLES-1) : '0;

  typedef enum logic {S_IDLE = 1'b0, S_BLANK = 1'b1} state_t;

  state_t                   r_state, w_state_nxt;
  logic [MUXT_WIDTH-1:0]    r_data;
  logic [MUXT_SELWIDTH-1:0] r_active, r_target;
  logic [CW-1:0]            r_cnt;
  logic                     r_done;

  logic                     w_eff_req, w_in_range, w_accept, w_same;
  logic                     w_start_blank, w_jump, w_complete;
  logic [MUXT_SELWIDTH-1:0] w_eff_sel;

  // Unused select codes map to blank so every index is defined.
  logic [MUXT_WIDTH-1:0] w_ch [NSEL];
  for (genvar k = 0; k < NSEL; k++) begin : g_ch
    if (k < MUXT_CHANNELS) begin : g_real
      assign w_ch[k] = CC_MUXT_data_InBUS[k*MUXT_WIDTH +: MUXT_WIDTH];
    end else begin : g_pad
      assign w_ch[k] = MUXT_BLANK;
    end
  end

`ifdef CC_MUXT_PENDING_EN
  logic                     r_pend_vld, r_go;
  logic [MUXT_SELWIDTH-1:0] r_pend_sel, r_go_sel;
  logic                     w_pv;
  logic [MUXT_SELWIDTH-1:0] w_ps;

  // A request on the completion edge itself is the latest one and wins.
  assign w_pv = (r_state == S_BLANK && CC_MUXT_req_In) ? 1'b1 : r_pend_vld;
  assign w_ps = (r_state == S_BLANK && CC_MUXT_req_In) ? CC_MUXT_select_InBUS : r_pend_sel;

  always_ff @(posedge CC_MUXT_CLOCK_50) begin
    if (CC_MUXT_RESET_InHigh) begin
      r_pend_vld <= 1'b0;
      r_pend_sel <= '0;
      r_go       <= 1'b0;
      r_go_sel   <= '0;
    end else begin
      r_go <= 1'b0;
      if (r_state == S_BLANK) begin
        if (w_complete) begin
          r_go       <= w_pv && (32'(w_ps) < MUXT_CHANNELS);
          r_go_sel   <= w_ps;
          r_pend_vld <= 1'b0;
        end else begin
          r_pend_vld <= w_pv;
          r_pend_sel <= w_ps;
        end
      end
    end
  end

  // A launched pending request takes priority over the live port in the done cycle.
  assign w_eff_req = r_go | CC_MUXT_req_In;
  assign w_eff_sel = r_go ? r_go_sel : CC_MUXT_select_InBUS;
`else
  assign w_eff_req = CC_MUXT_req_In;
  assign w_eff_sel = CC_MUXT_select_InBUS;
`endif

  assign w_in_range    = 32'(w_eff_sel) < MUXT_CHANNELS;
  assign w_accept      = (r_state == S_IDLE) && w_eff_req && w_in_range;
  assign w_same        = (w_eff_sel == r_active);
  assign w_start_blank = w_accept && !w_same && HAS_HOLD;
  assign w_jump        = w_accept && !w_same && !HAS_HOLD;
  assign w_complete    = (r_state == S_BLANK) && (r_cnt == '0);

  always_ff @(posedge CC_MUXT_CLOCK_50) begin
    if (CC_MUXT_RESET_InHigh) r_state <= S_IDLE;
    else                      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_blank) w_state_nxt = S_BLANK;
      S_BLANK: if (w_complete)    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    CC_MUXT_busy_Out      = (r_state == S_BLANK);
    CC_MUXT_data_OutBUS   = r_data;
    CC_MUXT_active_OutBUS = r_active;
    CC_MUXT_done_Out      = r_done;
  end

  always_ff @(posedge CC_MUXT_CLOCK_50) begin
    if (CC_MUXT_RESET_InHigh) begin
      r_data   <= MUXT_BLANK;
      r_active <= '0;
      r_target <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_data <= w_ch[r_active];
          if (w_accept && w_same) begin
            r_done <= 1'b1;
          end else if (w_jump) begin
            r_active <= w_eff_sel;
            r_data   <= w_ch[w_eff_sel];
            r_done   <= 1'b1;
          end else if (w_start_blank) begin
            r_target <= w_eff_sel;
            r_cnt    <= CNT_LOAD;
            r_data   <= MUXT_BLANK;
          end
        end
        S_BLANK: begin
          if (w_complete) begin
            r_active <= r_target;
            r_data   <= w_ch[r_target];
            r_done   <= 1'b1;
          end else begin
            r_cnt  <= r_cnt - 1'b1;
            r_data <= MUXT_BLANK;
          end
        end
        default: r_data <= MUXT_BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_cc_muxtransi_seq.sv
// Bench for cc_muxtransi_seq: directed vector table, hand sequences, and random
// traffic against a cycle model, on three builds (4ch/hold3, 3ch/hold3, 4ch/hold0).
module tb_cc_muxtransi_seq;

  logic        clk = 1'b0;
  logic        rst, req;
  logic [1:0]  sel;
  logic [31:0] data;

  logic [7:0] oA, oB, oC;
  logic [1:0] aA, aB, aC;
  logic       bA, bB, bC, dA, dB, dC;

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;

  always #5 clk = ~clk;

  cc_muxtransi_seq #(.MUXT_WIDTH(8), .MUXT_CHANNELS(4), .MUXT_SELWIDTH(2),
                     .MUXT_HOLDCYCLES(3), .MUXT_BLANK(8'h00)) dutA (
    .CC_MUXT_CLOCK_50(clk), .CC_MUXT_RESET_InHigh(rst), .CC_MUXT_data_InBUS(data),
    .CC_MUXT_select_InBUS(sel), .CC_MUXT_req_In(req), .CC_MUXT_data_OutBUS(oA),
    .CC_MUXT_active_OutBUS(aA), .CC_MUXT_busy_Out(bA), .CC_MUXT_done_Out(dA));

  cc_muxtransi_seq #(.MUXT_WIDTH(8), .MUXT_CHANNELS(3), .MUXT_SELWIDTH(2),
                     .MUXT_HOLDCYCLES(3), .MUXT_BLANK(8'h00)) dutB (
    .CC_MUXT_CLOCK_50(clk), .CC_MUXT_RESET_InHigh(rst), .CC_MUXT_data_InBUS(data[23:0]),
    .CC_MUXT_select_InBUS(sel), .CC_MUXT_req_In(req), .CC_MUXT_data_OutBUS(oB),
    .CC_MUXT_active_OutBUS(aB), .CC_MUXT_busy_Out(bB), .CC_MUXT_done_Out(dB));

  cc_muxtransi_seq #(.MUXT_WIDTH(8), .MUXT_CHANNELS(4), .MUXT_SELWIDTH(2),
                     .MUXT_HOLDCYCLES(0), .MUXT_BLANK(8'h00)) dutC (
    .CC_MUXT_CLOCK_50(clk), .CC_MUXT_RESET_InHigh(rst), .CC_MUXT_data_InBUS(data),
    .CC_MUXT_select_InBUS(sel), .CC_MUXT_req_In(req), .CC_MUXT_data_OutBUS(oC),
    .CC_MUXT_active_OutBUS(aC), .CC_MUXT_busy_Out(bC), .CC_MUXT_done_Out(dC));

  // Model: rem counts blank cycles still to be shown; busy is simply rem>0.
  typedef struct {
    logic [7:0] out;
    int act, rem, tgt, ps, gs;
    bit done, pv, go;
  } mst_t;

  mst_t mA, mB, mC;

  function automatic mst_t mclear();
    mst_t n;
    n.out = 8'h00; n.act = 0; n.rem = 0; n.tgt = 0; n.ps = 0; n.gs = 0;
    n.done = 0; n.pv = 0; n.go = 0;
    return n;
  endfunction

  function automatic mst_t mstep(mst_t s, int ch, int hold, bit r_in, bit q_in,
                                 int sel_in, logic [31:0] d);
    mst_t n;
    bit r;
    int q;
    n = s;
    if (r_in) return mclear();
    n.done = 0;
    if (s.rem > 0) begin
`ifdef CC_MUXT_PENDING_EN
      if (q_in) begin n.pv = 1; n.ps = sel_in; end
`endif
      n.rem = s.rem - 1;
      if (n.rem == 0) begin
        n.act  = s.tgt;
        n.out  = d[s.tgt*8 +: 8];
        n.done = 1;
        n.go   = n.pv && (n.ps < ch);
        n.gs   = n.ps;
        n.pv   = 0;
      end else begin
        n.out = 8'h00;
      end
    end else begin
      r = q_in; q = sel_in;
      if (s.go) begin r = 1; q = s.gs; end
      n.go  = 0;
      n.out = d[s.act*8 +: 8];
      if (r && q < ch) begin
        if (q == s.act) n.done = 1;
        else if (hold == 0) begin
          n.act = q; n.out = d[q*8 +: 8]; n.done = 1;
        end else begin
          n.tgt = q; n.rem = hold; n.out = 8'h00;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [11:0] mvec(mst_t m);
    return {m.out, 2'(m.act), (m.rem > 0), m.done};
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc %0d: got out=%h act=%0d busy=%b done=%b, want out=%h act=%0d busy=%b done=%b",
               name, cyc_n, got[11:4], got[3:2], got[1], got[0], exp[11:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // One clock: drive, step models on the edge, compare every DUT to its model.
  task automatic cyc(input bit r_i, input bit q_i, input logic [1:0] s_i);
    rst = r_i; req = q_i; sel = s_i;
    @(posedge clk);
    mA = mstep(mA, 4, 3, r_i, q_i, int'(s_i), data);
    mB = mstep(mB, 3, 3, r_i, q_i, int'(s_i), {8'h00, data[23:0]});
    mC = mstep(mC, 4, 0, r_i, q_i, int'(s_i), data);
    #1;
    cyc_n++;
    chk("modelA", {oA, aA, bA, dA}, mvec(mA));
    chk("modelB", {oB, aB, bB, dB}, mvec(mB));
    chk("modelC", {oC, aC, bC, dC}, mvec(mC));
  endtask

  typedef struct {
    bit         rst, req;
    logic [1:0] sel;
    logic [7:0] out;
    logic [1:0] act;
    bit         busy, done;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(bit r, bit q, logic [1:0] s, logic [7:0] o,
                              logic [1:0] a, bit b, bit d);
    vec_t v;
    v.rst = r; v.req = q; v.sel = s; v.out = o; v.act = a; v.busy = b; v.done = d;
    return v;
  endfunction

  initial begin
    mA = mclear(); mB = mclear(); mC = mclear();
    rst = 1'b1; req = 1'b0; sel = 2'd0; data = 32'h13121110;

    tbl[0]  = mk(1,1,2, 8'h00,0,0,0);  // reset beats request
    tbl[1]  = mk(0,0,0, 8'h10,0,0,0);
    tbl[2]  = mk(0,1,2, 8'h00,0,1,0);
    tbl[3]  = mk(0,0,0, 8'h00,0,1,0);
    tbl[4]  = mk(0,0,0, 8'h00,0,1,0);
    tbl[5]  = mk(0,0,0, 8'h12,2,0,1);
    tbl[6]  = mk(0,0,0, 8'h12,2,0,0);
    tbl[7]  = mk(0,1,2, 8'h12,2,0,1);  // same channel: no blank
    tbl[8]  = mk(0,0,0, 8'h12,2,0,0);
    tbl[9]  = mk(0,1,1, 8'h00,2,1,0);
    tbl[10] = mk(0,0,0, 8'h00,2,1,0);
    tbl[11] = mk(1,0,0, 8'h00,0,0,0);  // reset in second blank cycle
    tbl[12] = mk(0,0,0, 8'h10,0,0,0);
    tbl[13] = mk(0,1,1, 8'h00,0,1,0);
    tbl[14] = mk(0,0,0, 8'h00,0,1,0);
    tbl[15] = mk(0,0,0, 8'h00,0,1,0);
    tbl[16] = mk(0,0,0, 8'h11,1,0,1);
    tbl[17] = mk(0,1,3, 8'h00,1,1,0);  // back-to-back during done
    tbl[18] = mk(0,0,0, 8'h00,1,1,0);
    tbl[19] = mk(0,0,0, 8'h00,1,1,0);
    tbl[20] = mk(0,0,0, 8'h13,3,0,1);

    @(negedge clk);
    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].rst, tbl[i].req, tbl[i].sel);
      chk($sformatf("vec%0d", i), {oA, aA, bA, dA},
          {tbl[i].out, tbl[i].act, tbl[i].busy, tbl[i].done});
    end

    // Out-of-range on the 3-channel build; direct jump on the hold-0 build.
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 3);
    chk("oorB", {oB, aB, bB, dB}, {8'h10, 2'd0, 1'b0, 1'b0});
    chk("hold0C", {oC, aC, bC, dC}, {8'h13, 2'd3, 1'b0, 1'b1});
    cyc(0, 0, 0);
    chk("oorB2", {oB, aB, bB, dB}, {8'h10, 2'd0, 1'b0, 1'b0});
    chk("hold0C2", {oC, aC, bC, dC}, {8'h13, 2'd3, 1'b0, 1'b0});

    // Request during blank: select toggled to 3 and pulsed.
    cyc(1, 0, 0);
    cyc(0, 1, 1);
    cyc(0, 1, 3);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("land1", {oA, aA, bA, dA}, {8'h11, 2'd1, 1'b0, 1'b1});
`ifdef CC_MUXT_PENDING_EN
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0);
      chk($sformatf("pendblank%0d", i), {oA, aA, bA, dA}, {8'h00, 2'd1, 1'b1, 1'b0});
    end
    cyc(0, 0, 0);
    chk("land3", {oA, aA, bA, dA}, {8'h13, 2'd3, 1'b0, 1'b1});
`else
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0);
      chk($sformatf("stay1_%0d", i), {oA, aA, bA, dA}, {8'h11, 2'd1, 1'b0, 1'b0});
    end
`endif

    // Random traffic with changing data.
    cyc(1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      data = $urandom;
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 35),
          2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cc_muxtransi_seq.md
# cc_muxtransi_seq

Parametrised N-channel registered source multiplexer with sequenced transitions, for the display/game pipeline where screens or layers are switched. A change of source is requested through a handshake. The block blanks its output for a programmable number of cycles, then switches to the new channel and pulses a completion flag. It replaces ad-hoc two-input select muxes wherever a switch must be clean, glitch-free and observable by the control FSM.

## Interface
- MUXT_WIDTH, 8, data width per channel
- MUXT_CHANNELS, 4, number of input channels (>=2)
- MUXT_SELWIDTH, 2, select width; must satisfy 2^MUXT_SELWIDTH >= MUXT_CHANNELS
- MUXT_HOLDCYCLES, 3, blank cycles inserted on a channel change (0 allowed)
- MUXT_BLANK, 0, value driven on the output while blanking and after reset

Ports:
- CC_MUXT_CLOCK_50  in  1  single system clock, rising edge
- CC_MUXT_RESET_InHigh  in  1  synchronous, active-high reset
- CC_MUXT_data_InBUS  in  MUXT_CHANNELS*MUXT_WIDTH  flattened channel data; channel k at [k*MUXT_WIDTH +: MUXT_WIDTH]
- CC_MUXT_select_InBUS  in  MUXT_SELWIDTH  requested channel index
- CC_MUXT_req_In  in  1  switch request, sampled on each rising edge
- CC_MUXT_data_OutBUS  out  MUXT_WIDTH  registered output data
- CC_MUXT_active_OutBUS  out  MUXT_SELWIDTH  currently selected channel
- CC_MUXT_busy_Out  out  1  transition in progress; requests are not accepted
- CC_MUXT_done_Out  out  1  one-cycle pulse when a switch completes

## Operation
- FSM with two states:
  - IDLE: data_OutBUS <= channel[active] on every edge.
  - BLANK: data_OutBUS <= MUXT_BLANK; a down-counter of width clog2(MUXT_HOLDCYCLES+1) runs.
- Acceptance:
  - A request is accepted when req_In=1 and state=IDLE and select_InBUS < MUXT_CHANNELS.
  - select_InBUS is latched into a target register at acceptance. Later changes to select_InBUS have no effect on the transition in progress.
- Out-of-range select (>= MUXT_CHANNELS):
  - The request is ignored; no state change and no done pulse.
  - active and output are unchanged.
- Same-channel request (select == active):
  - Accepted with no blanking. The output keeps streaming and done_Out pulses.
- Different channel with MUXT_HOLDCYCLES>0:
  - IDLE goes to BLANK and the counter loads MUXT_HOLDCYCLES-1.
  - In BLANK, when counter==0: active <= target, data_OutBUS <= channel[target], done_Out <= 1, state goes to IDLE.
  - Otherwise the counter decrements.
- MUXT_HOLDCYCLES=0: a change switches directly in the accepting edge, with done pulse and no BLANK state.
- busy_Out is 1 exactly while state=BLANK.
- A request while busy is ignored (see Configuration).
- done_Out is registered. It is 1 for exactly one cycle and 0 otherwise.

## Timing
- Reset values (edge with RESET_InHigh=1): state IDLE, data_OutBUS=MUXT_BLANK, active=0, busy=0, done=0, counter=0, pending cleared.
- Reset wins over any simultaneous request.
- Reset during BLANK aborts the transition: active returns to 0 and the target is discarded.
- In IDLE, data latency from input to output is 1 clock.
- Request accepted at edge E0 (changing channel):
  - Output is MUXT_BLANK for exactly MUXT_HOLDCYCLES cycles after E0.
  - New channel data appears, and done_Out=1, after edge E0+MUXT_HOLDCYCLES.
  - busy_Out is 1 for cycles E0+1 .. E0+MUXT_HOLDCYCLES and falls in the same cycle done_Out rises.
- Same-channel request accepted at E0: done_Out=1 in the cycle after E0, busy stays 0.
- Back-to-back: a request presented while done_Out=1 is accepted (state is IDLE) on that edge.

## Configuration
- CC_MUXT_PENDING_EN defined:
  - A one-deep pending register captures {req, select} presented while busy; the latest request wins.
  - At the completion edge, the pending request is evaluated with the IDLE acceptance rules and the register is cleared.
  - An accepted pending request starts its transition on the edge after done, so no cycle is lost beyond the done cycle.
  - Out-of-range pending requests are dropped.
- Undefined: requests while busy are discarded, with no storage.

## Test plan
- Reset, then CHANNELS=4, channel k data=8'h10+k, req select=2 at E0, HOLD=3 -> output 8'h00 for 3 cycles, then 8'h12 with done=1 for 1 cycle, active=2, busy high exactly 3 cycles.
- active=2, req select=2 -> done=1 the next cycle, output stays 8'h12 uninterrupted, busy never asserted.
- MUXT_CHANNELS=3, req select=3 -> no busy, no done, active and output unchanged.
- During BLANK toward channel 1, toggle select to 3 and pulse req:
  - Without the macro: lands on channel 1 only.
  - With CC_MUXT_PENDING_EN: lands on 1 (done), then blanks 3 cycles and lands on 3 (second done).
- Assert reset in the second BLANK cycle -> next cycle output 8'h00, active=0, busy=0, done=0; a subsequent req select=1 completes normally.
- HOLD=0 build, req select=3 -> the next cycle shows channel 3 data with done=1 and no blank cycle.
